// File: rtl/dl_pkg.sv
// Shared helpers for the dl_ family of queue blocks.
`ifndef DL_PKG_SV
`define DL_PKG_SV

package dl_pkg;

    // Pointer and occupancy width: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`endif

// File: rtl/dl_counter.sv
// Free-running wrap counter with enable; used for the FIFO read and write pointers.
`ifndef DL_COUNTER_SV
`define DL_COUNTER_SV

module dl_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (en) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

`endif

// File: rtl/dl_fifo.sv
// Show-ahead synchronous FIFO with registered overflow/underflow pulses.
`ifndef DL_FIFO_SV
`define DL_FIFO_SV

module dl_fifo
    import dl_pkg::*;
#(
    parameter int NUM_BITS = 1,
    parameter int DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [NUM_BITS-1:0]            push_data,
    input  logic                           pop,
    output logic [NUM_BITS-1:0]            pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [ptr_width(DEPTH)-1:0]    count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [NUM_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    // Occupancy is the pointer distance; the wrap bit keeps full and empty distinct.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == PW'(DEPTH));
    assign empty = (count == '0);

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    dl_counter #(.WIDTH(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (do_push),
        .value (wr_ptr)
    );

    dl_counter #(.WIDTH(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (do_pop),
        .value (rd_ptr)
    );

    // Storage is deliberately not reset; empty masks any stale entry.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push & ~do_push;
            underflow <= pop & ~do_pop;
        end
    end

endmodule

`endif

// File: tb/tb_dl_fifo.sv
// Directed self-checking bench for dl_fifo (NUM_BITS=8, DEPTH=4).
module tb_dl_fifo;

    logic       clk;
    logic       rst_n;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic [7:0] pop_data;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    dl_fifo #(.NUM_BITS(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic p, input logic [7:0] d, input logic q);
        push      = p;
        push_data = d;
        pop       = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = 8'h00;

        #12;
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_pop_data", pop_data, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_underflow", underflow, 0);
        rst_n = 1'b1;

        // Fill to full
        applyStimulus(1, 8'h11, 0);
        checkOutput("fill1_count", count, 1);
        checkOutput("fill1_head", pop_data, 8'h11);
        checkOutput("fill1_empty", empty, 0);
        applyStimulus(1, 8'h22, 0);
        applyStimulus(1, 8'h33, 0);
        applyStimulus(1, 8'h44, 0);
        checkOutput("fill_full", full, 1);
        checkOutput("fill_count", count, 4);

        // Push alone while full
        applyStimulus(1, 8'h55, 0);
        checkOutput("ovf_pulse", overflow, 1);
        checkOutput("ovf_count", count, 4);
        checkOutput("ovf_head", pop_data, 8'h11);
        applyStimulus(0, 8'h00, 0);
        checkOutput("ovf_clear", overflow, 0);

        // Drain in order
        checkOutput("drain0", pop_data, 8'h11);
        applyStimulus(0, 8'h00, 1);
        checkOutput("drain1", pop_data, 8'h22);
        applyStimulus(0, 8'h00, 1);
        checkOutput("drain2", pop_data, 8'h33);
        applyStimulus(0, 8'h00, 1);
        checkOutput("drain3", pop_data, 8'h44);
        applyStimulus(0, 8'h00, 1);
        checkOutput("drain_empty", empty, 1);
        checkOutput("drain_count", count, 0);
        checkOutput("drain_pop_data", pop_data, 0);

        // Push and pop together while empty
        applyStimulus(1, 8'hA5, 1);
        checkOutput("udf_pulse", underflow, 1);
        checkOutput("udf_head", pop_data, 8'hA5);
        checkOutput("udf_count", count, 1);
        applyStimulus(0, 8'h00, 0);
        checkOutput("udf_clear", underflow, 0);
        applyStimulus(0, 8'h00, 1);
        checkOutput("udf_drain_empty", empty, 1);

        // Push and pop together while full
        applyStimulus(1, 8'h11, 0);
        applyStimulus(1, 8'h22, 0);
        applyStimulus(1, 8'h33, 0);
        applyStimulus(1, 8'h44, 0);
        applyStimulus(1, 8'h66, 1);
        checkOutput("fullpp_count", count, 4);
        checkOutput("fullpp_full", full, 1);
        checkOutput("fullpp_overflow", overflow, 0);
        checkOutput("fullpp_head0", pop_data, 8'h22);
        applyStimulus(0, 8'h00, 1);
        checkOutput("fullpp_head1", pop_data, 8'h33);
        applyStimulus(0, 8'h00, 1);
        checkOutput("fullpp_head2", pop_data, 8'h44);
        applyStimulus(0, 8'h00, 1);
        checkOutput("fullpp_head3", pop_data, 8'h66);
        applyStimulus(0, 8'h00, 1);
        checkOutput("fullpp_empty", empty, 1);

        // Push/pop pairs across several pointer wraps
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 8'(i), 0);
            checkOutput("wrap_head", pop_data, 32'(i));
            checkOutput("wrap_count", count, 1);
            applyStimulus(0, 8'h00, 1);
            checkOutput("wrap_empty", empty, 1);
            checkOutput("wrap_flags", {30'd0, overflow, underflow}, 0);
        end

        // Asynchronous reset mid-cycle with three entries held
        applyStimulus(1, 8'h01, 0);
        applyStimulus(1, 8'h02, 0);
        applyStimulus(1, 8'h03, 0);
        checkOutput("pre_rst_count", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_empty", empty, 1);
        checkOutput("arst_count", count, 0);
        checkOutput("arst_pop_data", pop_data, 0);
        checkOutput("arst_full", full, 0);
        #2;
        rst_n = 1'b1;
        applyStimulus(1, 8'h77, 0);
        checkOutput("post_rst_head", pop_data, 8'h77);
        checkOutput("post_rst_count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
